// File: rtl/utxd_crc_bl.sv
// UART block transmitter: header, optional memory data, trailing CRC-16.
// Frames are 8N1; the CRC is sent low byte first so the receiver residue is 0.
module utxd_crc_bl #(
  parameter int          NT       = 434,
  parameter logic [15:0] INIT_CRC = 16'hFFFF,
  parameter logic [15:0] POLY     = 16'hA001,
  parameter int          GAP      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st,
  input  logic [7:0]  com,
  input  logic [7:0]  lbl,
  input  logic [15:0] adr,
  output logic [15:0] rd_adr,
  input  logic [7:0]  rd_dat,
  output logic        UTXD,
  output logic        busy,
  output logic        en_tx_byte,
  output logic [7:0]  cb_byte,
  output logic [15:0] CRC,
  output logic        ok_tx_bl
);

  localparam int            TW    = $clog2(NT + 1);
  localparam logic [TW-1:0] T_END = TW'(NT - 1);
  localparam logic [15:0]   G_END = 16'(GAP * NT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, FRAME, GAPS, DONE
  } state_t;

  state_t        state;
  logic [7:0]    com_r;
  logic [7:0]    lbl_r;
  logic [15:0]   adr_r;
  logic [8:0]    nb;
  logic [8:0]    bcnt;
  logic [8:0]    nxt;
  logic [8:0]    ndat;
  logic [7:0]    sh;
  logic [3:0]    bit_i;
  logic [TW-1:0] tact;
  logic [15:0]   gcnt;
  logic          crc_on;
  logic          is_hd;
  logic          is_dat;
  logic          is_crl;
  logic          bit_end;
  logic          byte_end;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic        b
  );
    return (c[0] ^ b) ? ((c >> 1) ^ POLY) : (c >> 1);
  endfunction

  assign ndat    = (com == 8'h80 || com == 8'h81)
                 ? {1'b0, lbl} : 9'd0;
  assign nxt     = bcnt + 9'd1;
  assign cb_byte = bcnt[7:0];
  assign is_hd   = bcnt < 9'd4;
  assign is_dat  = !is_hd && (bcnt < nb - 9'd2);
  assign is_crl  = bcnt == nb - 9'd2;
  assign bit_end = (state == FRAME) && (tact == T_END);
  assign byte_end =
    (bit_end && bit_i == 4'd9 && GAP == 0) ||
    (state == GAPS && gcnt == G_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      UTXD       <= 1'b1;
      busy       <= 1'b0;
      en_tx_byte <= 1'b0;
      ok_tx_bl   <= 1'b0;
      CRC        <= INIT_CRC;
      rd_adr     <= 16'd0;
      bcnt       <= 9'd0;
      nb         <= 9'd6;
      bit_i      <= 4'd0;
      tact       <= '0;
      gcnt       <= 16'd0;
      sh         <= 8'd0;
      crc_on     <= 1'b0;
      com_r      <= 8'd0;
      lbl_r      <= 8'd0;
      adr_r      <= 16'd0;
    end else begin
      unique case (state)
        IDLE: if (st) begin
          com_r  <= com;
          lbl_r  <= lbl;
          adr_r  <= adr;
          nb     <= ndat + 9'd6;
          bcnt   <= 9'd0;
          busy   <= 1'b1;
          CRC    <= INIT_CRC;
          rd_adr <= adr;
          state  <= LOAD;
        end
        LOAD: begin
          state      <= FRAME;
          UTXD       <= 1'b0;
          en_tx_byte <= 1'b1;
          bit_i      <= 4'd0;
          tact       <= '0;
          crc_on     <= is_hd || is_dat;
          unique case (1'b1)
            is_hd: begin
              unique case (bcnt[1:0])
                2'd0: sh <= com_r;
                2'd1: sh <= lbl_r;
                2'd2: sh <= adr_r[15:8];
                2'd3: sh <= adr_r[7:0];
              endcase
            end
            is_dat: begin
              sh     <= rd_dat;
              rd_adr <= rd_adr + 16'd1;
            end
            is_crl:  sh <= CRC[7:0];
            default: sh <= CRC[15:8];
          endcase
        end
        FRAME: begin
          if (bit_end) begin
            tact <= '0;
            if (bit_i == 4'd9) begin
              en_tx_byte <= 1'b0;
              gcnt       <= 16'd0;
              state      <= GAPS;
            end else begin
              bit_i <= bit_i + 4'd1;
              if (bit_i == 4'd8) begin
                UTXD <= 1'b1;
              end else begin
                // data bit leaves LSB first and feeds the CRC as it goes
                UTXD <= sh[0];
                sh   <= {1'b0, sh[7:1]};
                if (crc_on) CRC <= crc_step(CRC, sh[0]);
              end
            end
          end else begin
            tact <= tact + TW'(1);
          end
        end
        GAPS: gcnt <= gcnt + 16'd1;
        DONE: begin
          ok_tx_bl <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (byte_end) begin
        bcnt <= nxt;
        if (nxt == nb) begin
          ok_tx_bl <= 1'b1;
          state    <= DONE;
        end else begin
          state <= LOAD;
        end
      end
    end
  end

endmodule

// File: tb/tb_utxd_crc_bl.sv
// Bench for utxd_crc_bl: bit-level UART capture against a
// byte-list model with a MODBUS CRC reference.
module tb_utxd_crc_bl;

  localparam int NT = 8;
  localparam int BT = 10 * NT + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        st;
  logic [7:0]  com;
  logic [7:0]  lbl;
  logic [15:0] adr;
  logic [15:0] rd_adr;
  logic [7:0]  rd_dat;
  logic        UTXD;
  logic        busy;
  logic        en_tx_byte;
  logic [7:0]  cb_byte;
  logic [15:0] CRC;
  logic        ok_tx_bl;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [15:0] alog[$];
  logic        log_en = 1'b0;

  utxd_crc_bl #(.NT(NT)) dut (
    .clk(clk), .rst(rst), .st(st), .com(com),
    .lbl(lbl), .adr(adr), .rd_adr(rd_adr),
    .rd_dat(rd_dat), .UTXD(UTXD), .busy(busy),
    .en_tx_byte(en_tx_byte), .cb_byte(cb_byte),
    .CRC(CRC), .ok_tx_bl(ok_tx_bl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_dat <= mem[rd_adr];
  always @(negedge clk)
    if (log_en && (alog.size() == 0 || rd_adr !== alog[$]))
      alog.push_back(rd_adr);

  function automatic logic [15:0] crc16(input logic [7:0] q[$]);
    logic [15:0] r = 16'hFFFF;
    foreach (q[i]) begin
      r = r ^ {8'h00, q[i]};
      for (int k = 0; k < 8; k++)
        r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic build(input logic [7:0] c, input logic [7:0] l,
                       input logic [15:0] a);
    logic [15:0] r;
    exp_q.delete();
    exp_q.push_back(c);
    exp_q.push_back(l);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    if (c == 8'h80 || c == 8'h81)
      for (int i = 0; i < int'(l); i++)
        exp_q.push_back(mem[16'(int'(a) + i)]);
    r = crc16(exp_q);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
  endtask

  task automatic start(input logic [7:0] c, input logic [7:0] l,
                       input logic [15:0] a);
    com = c; lbl = l; adr = a; st = 1'b1;
    tick;
    st = 1'b0;
    t0 = cyc;
    got_q.delete();
  endtask

  task automatic rx_byte(output logic [7:0] b, output bit good);
    int n = 0;
    bit ok = 1'b1;
    b = 8'h00;
    good = 1'b0;
    while (UTXD !== 1'b0 && n < 20 * NT) begin
      tick;
      n++;
    end
    if (UTXD !== 1'b0) return;
    repeat (NT / 2) tick;
    if (UTXD !== 1'b0) ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      repeat (NT) tick;
      b[k] = UTXD;
    end
    repeat (NT) tick;
    if (UTXD !== 1'b1) ok = 1'b0;
    good = ok;
  endtask

  task automatic rx_rest(input string tag, input int from);
    logic [7:0] b;
    bit g;
    int bad = 0;
    for (int i = from; i < exp_q.size(); i++) begin
      rx_byte(b, g);
      if (!g) begin
        bad++;
        break;
      end
      got_q.push_back(b);
    end
    chk({tag, "_framing"}, bad, 0);
  endtask

  task automatic finish_block(input string tag);
    int n = 0;
    int mm = 0;
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    foreach (got_q[i])
      if (i < exp_q.size() && got_q[i] !== exp_q[i]) mm++;
    chk({tag, "_bytes"}, mm, 0);
    chk({tag, "_residue"}, crc16(got_q), 16'h0000);
    while (ok_tx_bl !== 1'b1 && n < 4 * BT) begin
      tick;
      n++;
    end
    chk({tag, "_ok_delay"}, cyc - t0, exp_q.size() * BT);
    chk({tag, "_crc_out"}, CRC,
        {exp_q[exp_q.size()-1], exp_q[exp_q.size()-2]});
    com = 8'h80; lbl = 8'h03; st = 1'b1;
    tick;
    st = 1'b0;
    chk({tag, "_ok_pulse"}, {ok_tx_bl, busy}, 2'b00);
    tick;
    chk({tag, "_st_at_ok"}, busy, 1'b0);
  endtask

  task automatic run_block(input string tag, input logic [7:0] c,
                           input logic [7:0] l, input logic [15:0] a);
    build(c, l, a);
    alog.delete();
    start(c, l, a);
    log_en = 1'b1;
    rx_rest(tag, 0);
    finish_block(tag);
    log_en = 1'b0;
  endtask

  initial begin
    logic [7:0]  b0;
    logic [7:0]  cr;
    logic [15:0] ar;
    int          bu;
    int          be;
    int          n;
    logic        eu;

    for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
    rst = 1'b1; st = 1'b0; com = 8'h00; lbl = 8'h00; adr = 16'h0;
    repeat (3) tick;
    chk("rst_utxd", UTXD, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_en", en_tx_byte, 1'b0);
    chk("rst_cb", cb_byte, 8'h00);
    chk("rst_rdadr", rd_adr, 16'h0000);
    chk("rst_ok", ok_tx_bl, 1'b0);
    chk("rst_crc", CRC, 16'hFFFF);
    rst = 1'b0;
    tick;

    run_block("hdr_only", 8'h00, 8'h05, 16'h1234);
    chk("hdr_rdadr_n", alog.size(), 1);
    chk("hdr_rdadr", alog[0], 16'h1234);

    run_block("read3", 8'h80, 8'h03, 16'h00FE);
    chk("read3_log_n", alog.size(), 4);
    chk("read3_log0", alog[0], 16'h00FE);
    chk("read3_log1", alog[1], 16'h00FF);
    chk("read3_log2", alog[2], 16'h0100);
    chk("read3_d2", got_q[6], 8'h00);

    run_block("wrap", 8'h81, 8'h02, 16'hFFFF);
    chk("wrap_log_n", alog.size(), 3);
    chk("wrap_log1", alog[1], 16'h0000);
    chk("wrap_d0", got_q[4], 8'hFF);
    chk("wrap_d1", got_q[5], 8'h00);

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    run_block("lbl0_read", 8'h80, 8'h00, 16'h4000);
    ar = 16'($urandom);
    run_block("loop16", 8'h80, 8'd16, ar);

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(0, 3);
      cr = 8'($urandom);
      if (n == 0) cr = 8'h00;
      if (n == 1) cr = 8'h80;
      if (n == 2) cr = 8'h81;
      ar = 16'($urandom);
      run_block("rand", cr, 8'($urandom_range(0, 12)), ar);
    end

    // waveform of the first frame, with a stray st while busy
    build(8'h01, 8'h07, 16'h5A5A);
    start(8'h01, 8'h07, 16'h5A5A);
    bu = 0; be = 0; b0 = 8'h00;
    for (int i = 0; i < BT; i++) begin
      if (i == 20) begin
        com = 8'h80; lbl = 8'h09; st = 1'b1;
      end
      tick;
      st = 1'b0;
      n = i / NT;
      if (n == 0) eu = 1'b0;
      else if (n <= 8) eu = exp_q[0][n-1];
      else eu = 1'b1;
      if (UTXD !== eu) bu++;
      if (en_tx_byte !== (i < 10 * NT)) be++;
      if (n >= 1 && n <= 8 && i % NT == NT / 2) b0[n-1] = UTXD;
    end
    chk("wave_utxd", bu, 0);
    chk("wave_en", be, 0);
    got_q.push_back(b0);
    rx_rest("wave", 1);
    finish_block("wave");

    // reset in bit 4 of byte 2
    build(8'h80, 8'h08, 16'h2222);
    start(8'h80, 8'h08, 16'h2222);
    repeat (197) tick;
    chk("mid_cb", cb_byte, 8'h02);
    chk("mid_en", en_tx_byte, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_utxd", UTXD, 1'b1);
    chk("mid_busy", busy, 1'b0);
    chk("mid_crc", CRC, 16'hFFFF);
    repeat (2 * NT) tick;
    chk("mid_idle", UTXD, 1'b1);
    run_block("after_rst", 8'h81, 8'h05, 16'h7FFE);

    ar = 16'($urandom);
    run_block("lbl255", 8'h81, 8'hFF, ar);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
